bcd_to_bin_seq: RTL and testbench

//   Sequential packed-BCD to unsigned-binary converter: the inverse of the binary->BCD decode path.

---
 rtl/bcd_to_bin_seq_pkg.sv | 32 +++
 rtl/bcd_nibble_corr.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 116 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM encoding, digit constants and the result-width helper.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;
    localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [3:0] BCD_CORR        = 4'd3;

    // Smallest width that holds 10^digits - 1, i.e. ceil(log2(10^digits)).
    function automatic int bin_width(input int digits);
        logic [63:0] lim;
        int          w;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        w = 0;
        for (int b = 0; b < 64; b++) begin
            if ((64'd1 << b) < lim) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_nibble_corr.sv
// One-digit correction step of reverse double-dabble:
// a nibble that reached 8 or more after the right shift gets 3 taken off.
module bcd_nibble_corr
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= BCD_CORR_THRESH) ? nib_i - BCD_CORR : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned-binary converter, one shift-and-correct
// step per clock, with valid/ready handshakes on both sides.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = bin_width(DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_corr;
    logic [BIN_W-1:0]   bin_shift;
    logic [DIGITS-1:0]  nib_bad;
    logic               bcd_bad;

    // {bcd_q, bin_q} shifts right as one register; the BCD LSB feeds the binary MSB.
    assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_nibble_corr u_corr (
            .nib_i (bcd_shift[4*g +: 4]),
            .nib_o (bcd_corr[4*g +: 4])
        );
        assign nib_bad[g] = (bcd_in[4*g +: 4] > BCD_MAX_DIGIT);
    end

    assign bcd_bad = |nib_bad;

    // NOTE: every _d gets its hold value first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bcd_d     = bcd_in;
                    bin_d     = '0;
                    cnt_d     = '0;
                    bin_out_d = '0;
                    err_d     = bcd_bad;
                    state_d   = bcd_bad ? ST_DONE : ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = bcd_corr;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d   = ST_DONE;
                    bin_out_d = bin_shift;
                    err_d     = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: directed and random BCD groups on a 2-digit and a
// 3-digit converter, compared against a decimal-arithmetic reference.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [7:0]  bcd_in;
    logic [6:0]  bin_out;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, err3;
    logic [11:0] bcd_in3;
    logic [9:0]  bin_out3;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .bcd_in    (bcd_in3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .bin_out   (bin_out3),
        .err       (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decimal value of the digit group; any non-decimal nibble flags an error and yields 0.
    function automatic void ref_model(input logic [11:0] bcd, input int digits,
                                      output int val, output bit bad);
        logic [3:0] nib;
        val = 0;
        bad = 1'b0;
        for (int i = digits - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib > 4'd9) bad = 1'b1;
            val = val * 10 + int'(nib);
        end
        if (bad) val = 0;
    endfunction

    task automatic convert(input logic [7:0] bcd, input int hold);
        int exp_val;
        bit exp_err;
        int lat;
        ref_model({4'h0, bcd}, 2, exp_val, exp_err);

        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("idle_before_accept", in_ready, 1);

        in_valid = 1'b1;
        bcd_in   = bcd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in   = 8'($urandom);

        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, exp_err ? 0 : 7);
        check("bin_out", bin_out, exp_val);
        check("err", err, exp_err);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            bcd_in   = 8'($urandom);
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_bin_out", bin_out, exp_val);
            check("stall_err", err, exp_err);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic convert3(input logic [11:0] bcd);
        int exp_val;
        bit exp_err;
        int lat;
        ref_model(bcd, 3, exp_val, exp_err);

        in_valid3 = 1'b1;
        bcd_in3   = bcd;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        bcd_in3   = 12'($urandom);

        lat = 0;
        while (!out_valid3 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("d3_latency", lat, exp_err ? 0 : 10);
        check("d3_bin_out", bin_out3, exp_val);
        check("d3_err", err3, exp_err);
        @(posedge clk); #1;
        check("d3_release", in_ready3, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b1;
        bcd_in     = 8'h99;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        bcd_in3    = 12'h000;
        out_ready3 = 1'b1;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_bin_out", bin_out, 0);
            check("rst_err", err, 0);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", in_ready, 1);

        convert(8'h99, 0);
        convert(8'h00, 0);
        convert(8'h10, 0);
        convert(8'h09, 0);
        convert(8'h3A, 0);
        convert(8'h42, 0);
        convert(8'h57, 5);

        // Abort mid-conversion.
        in_valid = 1'b1;
        bcd_in   = 8'h88;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_bin_out", bin_out, 0);
        convert(8'h13, 0);

        for (int t = 0; t < 100; t++) begin
            convert({4'(t / 10), 4'(t % 10)}, 0);
        end

        repeat (40) begin
            convert(8'($urandom), $urandom_range(0, 2));
        end

        convert3(12'h999);
        convert3(12'h100);
        convert3(12'h000);
        convert3(12'h5C1);
        repeat (10) begin
            convert3({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
